// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler
//   Round-robin scheduler for four ultrasonic sensors. Fires one trigger at a
//   time, measures the synchronized echo high width of the active channel,
//   compares it to a distance threshold and updates that channel's detect flag.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = keep cycling slots; 0 = park in IDLE after the current slot
//   echo_i      raw asynchronous echo inputs, one per sensor
//   trigger_o   one-hot trigger outputs (at most one bit high)
//   led_detect  per-channel obstacle flags (1 = closer than threshold)
//   dist_o      last measured echo width in cycles (ECHO_TIMEOUT on timeout)
//   dist_ch     channel that dist_o belongs to
//   dist_valid  one-cycle strobe marking a dist_o/dist_ch update
//   busy        high in every state except IDLE
module ultrasonic_scheduler #(
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned ECHO_TIMEOUT  = 1500000,
    parameter int unsigned GUARD_CYCLES  = 500000,
    parameter int unsigned THRESH_CYCLES = 58000,
    parameter int unsigned CNT_W         = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [3:0]       echo_i,
    output logic [3:0]       trigger_o,
    output logic [3:0]       led_detect,
    output logic [CNT_W-1:0] dist_o,
    output logic [1:0]       dist_ch,
    output logic             dist_valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GUARD
    } state_t;

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] THRESH_VAL   = CNT_W'(THRESH_CYCLES);

    state_t           state, state_n;
    logic [1:0]       ch, ch_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       echo_m, echo_s;
    logic             echo_d;
    logic             echo_cur;
    logic             rise;
    logic [3:0]       led_n;
    logic [CNT_W-1:0] dist_n;
    logic [1:0]       dist_ch_n;
    logic             valid_n;

    // echo_d tracks the active channel every cycle (TRIG included), so a line
    // that is already high when WAIT_RISE starts never produces a rise.
    assign echo_cur = echo_s[ch];
    assign rise     = echo_cur & ~echo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ch         <= '0;
            cnt        <= '0;
            echo_m     <= '0;
            echo_s     <= '0;
            echo_d     <= 1'b0;
            led_detect <= '0;
            dist_o     <= '0;
            dist_ch    <= '0;
            dist_valid <= 1'b0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            cnt        <= cnt_n;
            echo_m     <= echo_i;
            echo_s     <= echo_m;
            echo_d     <= echo_cur;
            led_detect <= led_n;
            dist_o     <= dist_n;
            dist_ch    <= dist_ch_n;
            dist_valid <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        ch_n      = ch;
        cnt_n     = cnt + ONE;
        led_n     = led_detect;
        dist_n    = dist_o;
        dist_ch_n = dist_ch;
        valid_n   = 1'b0;
        trigger_o = '0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = S_TRIG;
                end
            end

            S_TRIG: begin
                trigger_o = 4'b0001 << ch;
                if (cnt == TRIG_LAST) begin
                    state_n = S_WAIT_RISE;
                    cnt_n   = '0;
                end
            end

            S_WAIT_RISE: begin
                if (rise) begin
                    // The rise cycle itself is the first high cycle.
                    state_n = S_MEASURE;
                    cnt_n   = ONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n   = S_GUARD;
                    cnt_n     = '0;
                    dist_n    = TIMEOUT_VAL;
                    dist_ch_n = ch;
                    led_n[ch] = 1'b0;
                    valid_n   = 1'b1;
                end
            end

            S_MEASURE: begin
                if (!echo_cur) begin
                    state_n   = S_GUARD;
                    cnt_n     = '0;
                    dist_n    = cnt;
                    dist_ch_n = ch;
                    led_n[ch] = (cnt < THRESH_VAL);
                    valid_n   = 1'b1;
                end else if (cnt == TIMEOUT_VAL) begin
                    state_n   = S_GUARD;
                    cnt_n     = '0;
                    dist_n    = TIMEOUT_VAL;
                    dist_ch_n = ch;
                    led_n[ch] = 1'b0;
                    valid_n   = 1'b1;
                end
            end

            S_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    ch_n    = ch + 2'd1;
                    cnt_n   = '0;
                    state_n = enable ? S_TRIG : S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
